mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Data-memory access unit sitting directly downstream of the memory-command generator in the MEM stage.
- Consumes the mem_en/mem_wr/mem_addr/mem_wdata command and runs one transaction per command on a req/ack data bus.
- Stalls the pipeline until the bus acknowledges, then presents load data to writeback.

Parameters:
TIMEOUT_CYCLES, 16, BUSY cycles without bus_ack before abort (only used with MEM_TIMEOUT_EN); must be >= 1.
CNT_W, 5, width of timeout counter; 2^CNT_W must be > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
mem_en  in  1  command valid; held stable by upstream while stall=1.
mem_wr  in  1  1=store, 0=load.
mem_addr  in  32  byte address.
mem_wdata  in  32  store data.
stall  out  1  combinational; freezes upstream pipeline.
load_data  out  32  registered load result.
load_valid  out  1  registered; 1 for exactly the DONE cycle of a completed load.
bus_req  out  1  registered request to data memory.
bus_we  out  1  registered write enable.
bus_addr  out  32  registered address.
bus_wdata  out  32  registered write data.
bus_rdata  in  32  read data; valid when bus_ack=1.
bus_ack  in  1  one-cycle acknowledge.
bus_err  out  1  registered; timeout abort flag.

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, load_data=0, load_valid=0, bus_err=0, counter=0.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE, mem_en=1:
  - stall=1.
  - At posedge: capture mem_addr/mem_wdata/mem_wr into bus_addr/bus_wdata/bus_we; set bus_req=1; go to BUSY.
- IDLE, mem_en=0: stall=0; no bus activity.
- BUSY:
  - stall=1; bus_req/bus_addr/bus_we/bus_wdata held constant.
  - On posedge with bus_ack=1: bus_req=0; go to DONE.
  - If load, load_data <= bus_rdata and load_valid <= 1.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle.
  - mem_en is ignored (it still shows the completed command); always go to IDLE.
  - load_valid and bus_err return to 0.
- Latency: command in IDLE -> earliest bus_ack in first BUSY cycle -> DONE. Minimum 3 cycles per access; each extra wait cycle adds one.
- Store: load_data unchanged; load_valid stays 0.
- bus_ack outside BUSY is ignored; bus_rdata is never sampled then.
- Back-to-back commands: the second command is accepted in the IDLE cycle after DONE, so there is no overlap.
- rst asserted in any state, including BUSY with bus_req=1: the outstanding transaction is dropped, bus_req=0 next cycle, all outputs take reset values. The bus slave tolerates req withdrawal.
- Address/data are passed unmodified, with no alignment check; the 32-bit width is preserved.

Optional Feature:
Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without bus_ack.
  - When counter reaches TIMEOUT_CYCLES-1 with no ack, the next posedge sets bus_req=0 and bus_err=1, and goes to DONE.
  - load_data is unchanged and load_valid=0.
  - An ack arriving on the same edge as the timeout wins: normal completion, bus_err=0.
- Undefined: no counter logic; bus_err tied 0; BUSY waits indefinitely.

Decomposition:
- Shared defines header:
  - state encodings MEM_ST_IDLE/MEM_ST_BUSY/MEM_ST_DONE;
  - default TIMEOUT_CYCLES;
  - bus width constant (32).
- Opcode definitions stay in the existing instruction-syntax header; this block does not decode opcodes.
- One natural sub-module, mem_timeout_cnt: counter plus expiry compare, instantiated only under MEM_TIMEOUT_EN.
- Everything else is a single FSM in mem_access.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_en=1 -> all outputs 0, bus_req never rises. Release -> bus_req=1 one cycle later.
- Load, zero-wait: mem_en=1, mem_wr=0, addr=0x00000010; bus_ack=1 with bus_rdata=0xDEADBEEF in first BUSY cycle -> stall=1 for 2 cycles, then DONE with load_valid=1, load_data=0xDEADBEEF.
- Store, 3-wait: mem_wr=1, addr=0x00000020, wdata=0x12345678; ack after 3 BUSY cycles -> bus_we=1, bus_addr/bus_wdata stable all 4 BUSY cycles, load_valid=0, load_data unchanged.
- Back-to-back: load 0x4 then store 0x8, ack immediate -> two separate bus_req pulses separated by DONE+IDLE. DONE never re-issues the first command.
- Reset mid-BUSY: rst=1 while bus_req=1 and no ack -> bus_req=0 next cycle, state IDLE, no load_valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> bus_err=1 for one cycle after 4 BUSY cycles, stall drops in that DONE cycle. Repeat with ack on the 4th BUSY cycle -> bus_err=0, normal completion.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants and state encoding for the MEM-stage data-memory access unit.
package mem_access_pkg;

  localparam int MEM_BUS_W           = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_if.sv
// req/ack data-memory bus between mem_access (master) and the data memory (slave).
interface mem_access_if;
  import mem_access_pkg::*;

  logic                 bus_req;
  logic                 bus_we;
  logic [MEM_BUS_W-1:0] bus_addr;
  logic [MEM_BUS_W-1:0] bus_wdata;
  logic [MEM_BUS_W-1:0] bus_rdata;
  logic                 bus_ack;
  logic                 bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/mem_access_timeout_cnt.sv
// BUSY-cycle counter with expiry compare; only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear on BUSY entry, count BUSY cycles without ack
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: one req/ack bus transaction per command, stalling until done.
// Optional bus timeout abort is enabled with `define MEM_TIMEOUT_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_en,
  input  logic                 mem_wr,
  input  logic [MEM_BUS_W-1:0] mem_addr,
  input  logic [MEM_BUS_W-1:0] mem_wdata,
  output logic                 stall,
  output logic [MEM_BUS_W-1:0] load_data,
  output logic                 load_valid,
  mem_access_if.master         bus
);

  if (TIMEOUT_CYCLES < 1 || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_params
    $error("mem_access: TIMEOUT_CYCLES must be >= 1 and < 2**CNT_W");
  end

  mem_state_e           state_q,      state_d;
  logic                 bus_req_q,    bus_req_d;
  logic                 bus_we_q,     bus_we_d;
  logic [MEM_BUS_W-1:0] bus_addr_q,   bus_addr_d;
  logic [MEM_BUS_W-1:0] bus_wdata_q,  bus_wdata_d;
  logic [MEM_BUS_W-1:0] load_data_q,  load_data_d;
  logic                 load_valid_q, load_valid_d;
  logic                 bus_err_q,    bus_err_d;
  logic                 timeout_s;

`ifdef MEM_TIMEOUT_EN
  logic expired_s;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     ((state_q == MEM_ST_IDLE) && mem_en),
    .inc_i     ((state_q == MEM_ST_BUSY) && !bus.bus_ack),
    .expired_o (expired_s)
  );

  assign timeout_s = (state_q == MEM_ST_BUSY) && expired_s;
`else
  assign timeout_s = 1'b0;
`endif

  // next-state and next-output logic; an ack on the timeout edge takes priority
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = load_valid_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      MEM_ST_IDLE: begin
        if (mem_en) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_wr;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          state_d     = MEM_ST_BUSY;
        end else begin
          state_d = MEM_ST_IDLE;
        end
      end
      MEM_ST_BUSY: begin
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = MEM_ST_DONE;
          if (!bus_we_q) begin
            load_data_d  = bus.bus_rdata;
            load_valid_d = 1'b1;
          end else begin
            load_valid_d = 1'b0;
          end
        end else if (timeout_s) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = MEM_ST_DONE;
        end else begin
          state_d = MEM_ST_BUSY;
        end
      end
      MEM_ST_DONE: begin
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        state_d      = MEM_ST_IDLE;
      end
      default: begin
        bus_req_d    = 1'b0;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        state_d      = MEM_ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MEM_ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= {MEM_BUS_W{1'b0}};
      bus_wdata_q  <= {MEM_BUS_W{1'b0}};
      load_data_q  <= {MEM_BUS_W{1'b0}};
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // stall is held low during reset so every output shows its reset value
  assign stall = !rst && (((state_q == MEM_ST_IDLE) && mem_en) || (state_q == MEM_ST_BUSY));

  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed and randomized transactions against a transaction-level model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] model_ld;

  mem_access_if bus_if ();

  mem_access #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // One full command: cycle 0 is the IDLE accept cycle, 1..waits+1 are BUSY, waits+2 is DONE.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input string tag);
    logic [31:0] old_ld;
    logic        exp_stall, exp_req;
    old_ld = model_ld;
    if (!wr) model_ld = rdata;
    for (int k = 0; k <= waits + 2; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; mem_en = 1'b1; mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
      if (k == waits + 1) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
      end else if (k == 0 || k == waits + 2) begin
        bus_if.bus_ack = 1'($urandom); bus_if.bus_rdata = $urandom;
      end else begin
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
      end
      @(negedge clk);
      exp_stall = (k <= waits + 1);
      exp_req   = (k >= 1 && k <= waits + 1);
      n_cmp++;
      if (stall !== exp_stall) begin
        n_fail++; $display("FAIL %s stall k=%0d: got %b want %b", tag, k, stall, exp_stall);
      end
      n_cmp++;
      if (bus_if.bus_req !== exp_req) begin
        n_fail++; $display("FAIL %s bus_req k=%0d: got %b want %b", tag, k, bus_if.bus_req, exp_req);
      end
      if (exp_req) begin
        n_cmp++;
        if (bus_if.bus_we !== wr || bus_if.bus_addr !== addr || (wr && bus_if.bus_wdata !== wdata)) begin
          n_fail++;
          $display("FAIL %s bus_cmd k=%0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   tag, k, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, wr, addr, wdata);
        end
      end
      n_cmp++;
      if (load_valid !== (k == waits + 2 && !wr)) begin
        n_fail++; $display("FAIL %s load_valid k=%0d: got %b want %b", tag, k, load_valid, (k == waits + 2 && !wr));
      end
      n_cmp++;
      if (load_data !== ((k == waits + 2) ? model_ld : old_ld)) begin
        n_fail++;
        $display("FAIL %s load_data k=%0d: got %h want %h", tag, k, load_data, (k == waits + 2) ? model_ld : old_ld);
      end
      n_cmp++;
      if (bus_if.bus_err !== 1'b0) begin
        n_fail++; $display("FAIL %s bus_err k=%0d: got %b want 0", tag, k, bus_if.bus_err);
      end
    end
  endtask

  // Idle cycle with random noise on ack/rdata, which must be ignored.
  task automatic idle(input string tag);
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wr = 1'($urandom);
    bus_if.bus_ack = 1'($urandom); bus_if.bus_rdata = $urandom;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || bus_if.bus_req !== 1'b0 || load_valid !== 1'b0 || bus_if.bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: got stall=%b req=%b lv=%b err=%b want all 0",
               tag, stall, bus_if.bus_req, load_valid, bus_if.bus_err);
    end
    n_cmp++;
    if (load_data !== model_ld) begin
      n_fail++; $display("FAIL %s idle load_data: got %h want %h", tag, load_data, model_ld);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      rst = 1'b1; mem_en = 1'b1; bus_if.bus_ack = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b0 || bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0 || bus_if.bus_err !== 1'b0 ||
          load_valid !== 1'b0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0 || load_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset k=%0d: got stall=%b req=%b we=%b err=%b lv=%b addr=%h wd=%h ld=%h want all 0",
                 k, stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_err, load_valid,
                 bus_if.bus_addr, bus_if.bus_wdata, load_data);
      end
    end
    model_ld = 32'h0;
    // release with mem_en still high: bus_req must rise one cycle later
    access(1'b0, 32'h0000_0100, 32'h0, 0, 32'hA5A5_0001, "reset_release");
    idle("reset_release");
  endtask

  task automatic test_load_zero_wait();
    access(1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, "load0");
    idle("load0");
  endtask

  task automatic test_store_wait3();
    access(1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hFFFF_FFFF, "store3");
    idle("store3");
  endtask

  task automatic test_back_to_back();
    access(1'b0, 32'h0000_0004, 32'h0, 0, 32'hCAFE_0004, "b2b_load");
    access(1'b1, 32'h0000_0008, 32'h8888_0008, 0, 32'h0, "b2b_store");
    idle("b2b");
  endtask

  task automatic test_reset_mid_busy();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_0040; bus_if.bus_ack = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus_if.bus_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy pre: got bus_req=%b want 1", bus_if.bus_req);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    model_ld = 32'h0;
    n_cmp++;
    if (bus_if.bus_req !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0 || load_data !== 32'h0 ||
        bus_if.bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_busy post: got req=%b stall=%b lv=%b ld=%h addr=%h want 0",
               bus_if.bus_req, stall, load_valid, load_data, bus_if.bus_addr);
    end
    idle("rst_busy");
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h0BAD_F00D, "rst_busy_next");
  endtask

  task automatic test_random();
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom); addr = $urandom; wdata = $urandom; rdata = $urandom;
`ifdef MEM_TIMEOUT_EN
      waits = $urandom_range(0, 3);
`else
      waits = $urandom_range(0, 6);
`endif
      access(wr, addr, wdata, waits, rdata, "random");
      if ($urandom_range(0, 1) == 0) idle("random");
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] old_ld;
    old_ld = model_ld;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; mem_en = (k <= 5); mem_wr = 1'b0; mem_addr = 32'h0000_0030;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
      @(negedge clk);
      n_cmp++;
      if (stall !== (k <= 4) || bus_if.bus_req !== (k >= 1 && k <= 4) || bus_if.bus_err !== (k == 5)) begin
        n_fail++;
        $display("FAIL timeout k=%0d: got stall=%b req=%b err=%b want %b %b %b", k, stall,
                 bus_if.bus_req, bus_if.bus_err, (k <= 4), (k >= 1 && k <= 4), (k == 5));
      end
      n_cmp++;
      if (load_valid !== 1'b0 || load_data !== old_ld) begin
        n_fail++; $display("FAIL timeout k=%0d load: got lv=%b ld=%h want 0 %h", k, load_valid, load_data, old_ld);
      end
    end
    access(1'b0, 32'h0000_0034, 32'h0, 3, 32'h7777_1234, "ack_on_timeout");
    idle("ack_on_timeout");
  endtask
`else
  task automatic test_long_wait();
    access(1'b0, 32'h0000_0050, 32'h0, 20, 32'h5151_5151, "long_wait");
    idle("long_wait");
  endtask
`endif

  initial begin
    rst = 1'b1; mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    model_ld = 32'h0;
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
